fetch_sequencer: RTL and testbench

//  Sequences instruction fetch from the combinational instruction_memory (pc in -> data out).
//  - Owns the PC and drives imem_pc.
//  - Buffers fetched words in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
//  - Handles start, halt, branch/jump redirect and out-of-range PC.

---
 rtl/fetch_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, reads the combinational instruction
// memory, buffers {pc, instr} pairs in a small FIFO and hands them to decode
// over a valid/ready handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset; PC parked, waiting for start (redirects allowed)
// S_RUN   | fetching one word per cycle while the FIFO has room
// S_HALTED| fetch stopped by halt or out-of-range PC; FIFO still drains
//
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_flushed
// counters and their output ports.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        busy,
    output logic        err_range,
    output logic        err_align
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int          PW       = $clog2(DEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [31:0]     pc;
    logic [31:0]     fifo_pc    [DEPTH];
    logic [31:0]     fifo_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            pop;
    logic            room;
    logic            in_range;
    logic            push;
    logic            flush;
    logic            range_hit;

    assign pop      = (count != '0) && dec_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign room     = (count != CW'(DEPTH)) || pop;
    assign in_range = (pc < PC_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next state and per-edge fetch/flush decisions; halt outranks redirect,
    // which outranks start and fetch.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        flush      = 1'b0;
        range_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (halt)             state_next = S_HALTED;
                else if (redir_valid) flush = 1'b1;
                else if (start)       state_next = S_RUN;
            end
            S_RUN: begin
                if (halt)             state_next = S_HALTED;
                else if (redir_valid) flush = 1'b1;
                else if (room) begin
                    if (in_range) begin
                        push = 1'b1;
                    end else begin
                        range_hit  = 1'b1;
                        state_next = S_HALTED;
                    end
                end
            end
            default: ;
        endcase
    end

    // PC, FIFO storage/pointers and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            err_range <= 1'b0;
            err_align <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (flush) begin
            // Flush wins over any pop on the same edge.
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pc        <= {redir_pc[31:2], 2'b00};
            err_align <= err_align | (|redir_pc[1:0]);
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= pc;
                fifo_instr[wr_ptr] <= imem_data;
                wr_ptr             <= wr_ptr + 1'b1;
                pc                 <= pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (range_hit) err_range <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    // Fetch and flush statistics, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push)  perf_fetched <= perf_fetched + 32'd1;
            if (flush) perf_flushed <= perf_flushed + 32'(count);
        end
    end
`endif

    assign imem_pc   = pc;
    assign dec_valid = (count != '0);
    assign dec_instr = fifo_instr[rd_ptr];
    assign dec_pc    = fifo_pc[rd_ptr];
    assign busy      = (state == S_RUN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a stub instruction memory
// (word i = 32'hA000_0000 | i). Inputs change and outputs are sampled on the
// falling edge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, halt, redir_valid, dec_ready;
    logic [31:0] redir_pc, imem_pc, imem_data, dec_instr, dec_pc;
    logic        dec_valid, busy, err_range, err_align;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data = 32'hA000_0000 | (imem_pc >> 2);

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_pc     (imem_pc),
        .imem_data   (imem_data),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .busy        (busy),
        .err_range   (err_range),
        .err_align   (err_align)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; redir_valid = 1'b0;
        redir_pc = '0; dec_ready = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({dec_valid, busy, err_range, err_align} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {dec_valid, busy, err_range, err_align});
        end
        checks++;
        if (dec_instr !== 32'h0 || dec_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_head got instr %h pc %h exp 0 0", dec_instr, dec_pc);
        end
        checks++;
        if (imem_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got %h exp 00000000", imem_pc);
        end
    endtask

    task automatic test_stream();
        do_reset();
        dec_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (dec_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stream_e0 got valid %b busy %b exp 0 1", dec_valid, busy);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * k) || dec_instr !== (32'hA000_0000 | 32'(k))) begin
                errors++;
                $display("FAIL stream_%0d got v %b pc %h instr %h exp 1 %h %h", k, dec_valid,
                         dec_pc, dec_instr, 32'(4 * k), 32'hA000_0000 | 32'(k));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (imem_pc !== 32'h8 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            errors++;
            $display("FAIL bp_full got pc %h v %b head %h exp 8 1 0", imem_pc, dec_valid, dec_pc);
        end
        dec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * k)) begin
                errors++;
                $display("FAIL bp_drain_%0d got v %b pc %h exp 1 %h", k, dec_valid, dec_pc, 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        dec_ready = 1'b1;
        tick();
        checks++;
        if (dec_pc !== 32'h4 || imem_pc !== 32'hC) begin
            errors++;
            $display("FAIL redir_setup got head %h pc %h exp 4 c", dec_pc, imem_pc);
        end
        redir_valid = 1'b1;
        redir_pc = 32'h20;
        tick();
        redir_valid = 1'b0;
        checks++;
        if (dec_valid !== 1'b0 || imem_pc !== 32'h20) begin
            errors++;
            $display("FAIL redir_flush got v %b pc %h exp 0 20", dec_valid, imem_pc);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_flushed !== 32'd2 || perf_fetched !== 32'd3) begin
            errors++;
            $display("FAIL redir_perf got flushed %0d fetched %0d exp 2 3", perf_flushed, perf_fetched);
        end
`endif
        tick();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h20 || dec_instr !== 32'hA000_0008) begin
            errors++;
            $display("FAIL redir_target got v %b pc %h instr %h exp 1 20 a0000008", dec_valid, dec_pc, dec_instr);
        end
        checks++;
        if (err_align !== 1'b0) begin
            errors++;
            $display("FAIL redir_noalign got %b exp 0", err_align);
        end
    endtask

    task automatic test_align();
        redir_valid = 1'b1;
        redir_pc = 32'h22;
        tick();
        redir_valid = 1'b0;
        checks++;
        if (err_align !== 1'b1 || imem_pc !== 32'h20 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL align_flag got err %b pc %h v %b exp 1 20 0", err_align, imem_pc, dec_valid);
        end
        tick();
        checks++;
        if (dec_pc !== 32'h20 || dec_instr !== 32'hA000_0008) begin
            errors++;
            $display("FAIL align_resume got pc %h instr %h exp 20 a0000008", dec_pc, dec_instr);
        end
    endtask

    task automatic test_range();
        redir_valid = 1'b1;
        redir_pc = 32'hF0;
        tick();
        redir_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(32'hF0 + 4 * k)) begin
                errors++;
                $display("FAIL range_stream_%0d got v %b pc %h exp 1 %h", k, dec_valid, dec_pc, 32'(32'hF0 + 4 * k));
            end
        end
        dec_ready = 1'b0;
        tick();
        checks++;
        if (err_range !== 1'b1 || busy !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'hFC || imem_pc !== 32'h100) begin
            errors++;
            $display("FAIL range_halt got err %b busy %b v %b head %h pc %h exp 1 0 1 fc 100",
                     err_range, busy, dec_valid, dec_pc, imem_pc);
        end
        dec_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (dec_valid !== 1'b0 || err_range !== 1'b1) begin
            errors++;
            $display("FAIL range_drain got v %b err %b exp 0 1", dec_valid, err_range);
        end
    endtask

    task automatic test_halt();
        do_reset();
        checks++;
        if ({err_range, err_align, busy, dec_valid} !== 4'b0000 || imem_pc !== 32'h0) begin
            errors++;
            $display("FAIL halt_rst got flags %b pc %h exp 0000 0", {err_range, err_align, busy, dec_valid}, imem_pc);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (busy !== 1'b0 || imem_pc !== 32'h4 || dec_valid !== 1'b1) begin
            errors++;
            $display("FAIL halt_stop got busy %b pc %h v %b exp 0 4 1", busy, imem_pc, dec_valid);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        redir_valid = 1'b1;
        redir_pc = 32'h40;
        tick();
        redir_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || imem_pc !== 32'h4 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin
            errors++;
            $display("FAIL halt_ignore got busy %b pc %h v %b head %h exp 0 4 1 0", busy, imem_pc, dec_valid, dec_pc);
        end
        dec_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (dec_valid !== 1'b0 || imem_pc !== 32'h4) begin
            errors++;
            $display("FAIL halt_drain got v %b pc %h exp 0 4", dec_valid, imem_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dec_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        checks++;
        if ({dec_valid, busy, err_range, err_align} !== 4'b0000 || dec_pc !== 32'h0 ||
            dec_instr !== 32'h0 || imem_pc !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got flags %b pc %h instr %h imem %h exp 0000 0 0 0",
                     {dec_valid, busy, err_range, err_align}, dec_pc, dec_instr, imem_pc);
        end
        tick();
        checks++;
        if (dec_valid !== 1'b0 || busy !== 1'b0 || imem_pc !== 32'h0) begin
            errors++;
            $display("FAIL mid_idle got v %b busy %b pc %h exp 0 0 0", dec_valid, busy, imem_pc);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_align();
        test_range();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
